// File: rtl/alu_bram_sequencer_pkg.sv
// Shared types and constants for the BRAM-fed ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned RES_W        = 48;
  localparam int unsigned DISP_W       = 16;
  localparam int unsigned MEM_LAT_DEF  = 1;
  localparam int unsigned ALU_LAT_DEF  = 3;
  localparam int unsigned TICK_DIV_DEF = 100_000_000;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWaitMem = 3'd2,
    StWaitAlu = 3'd3,
    StCapture = 3'd4,
    StHold    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_bram_sequencer_if.sv
// Control, operand-memory/ALU and display signals of the sequencer.
interface alu_bram_sequencer_if #(
  parameter int unsigned ADDR_W = 4
) ();
  import alu_seq_pkg::*;

  logic              start;
  logic              stop;
  logic              continuous;
  logic              step_mode;
  logic              step;
  logic [1:0]        select_in;
  logic              carry_in;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        alu_select;
  logic              alu_carryin;
  logic [RES_W-1:0]  alu_p;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic [DISP_W-1:0] disp_value;
  logic              disp_sat;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, continuous, step_mode, step, select_in, carry_in, alu_p,
    output mem_en, mem_addr, alu_select, alu_carryin, result, result_valid,
           disp_value, disp_sat, busy, done
  );

  modport slave (
    output start, stop, continuous, step_mode, step, select_in, carry_in, alu_p,
    input  mem_en, mem_addr, alu_select, alu_carryin, result, result_valid,
           disp_value, disp_sat, busy, done
  );

endinterface

// File: rtl/alu_bram_sequencer_tick_gen.sv
// Display-step pacing counter: tick on the last count, restarts when cleared.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_bram_sequencer.sv
// Latency-aware sequencer: walks the operand address, waits out BRAM and ALU latency,
// captures P and paces steps for the display.
module alu_bram_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned LAST_ADDR = 15,
  parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
  parameter int unsigned ALU_LAT   = ALU_LAT_DEF,
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned DISP_MAX  = 9999
) (
  input logic                  clock_100Mhz,
  input logic                  reset_n,
  alu_bram_sequencer_if.master bus
);

  localparam int unsigned LatW = 8;

  seq_state_e        state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic              rv_q;
  logic [1:0]        sel_q;
  logic              cin_q;
  logic [RES_W-1:0]  result_q;
  logic [DISP_W-1:0] disp_q;
  logic              sat_q;
  logic              tick;
  logic              advance;
  logic              over_max;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock_100Mhz(clock_100Mhz),
    .reset_n     (reset_n),
    .clear       (state_q != StHold),
    .tick        (tick)
  );

  assign advance  = bus.step_mode ? bus.step : tick;
  assign over_max = (bus.alu_p > RES_W'(DISP_MAX));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    stop_d  = stop_q | (bus.stop & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        lat_d   = '0;
        state_d = StWaitMem;
      end
      StWaitMem: begin
        if (lat_q == LatW'(MEM_LAT - 1)) begin
          lat_d   = '0;
          state_d = StWaitAlu;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StWaitAlu: begin
        if (lat_q == LatW'(ALU_LAT - 1)) begin
          lat_d   = '0;
          state_d = StCapture;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StCapture: state_d = StHold;
      StHold: begin
        // A pending stop beats an advance in the same cycle.
        if (stop_d) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (advance) begin
          if (addr_q != ADDR_W'(LAST_ADDR)) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StIssue;
          end else if (bus.continuous) begin
            addr_d  = '0;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) stop_d = 1'b0;
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      addr_q   <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      sel_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      disp_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      rv_q    <= (state_q == StCapture);
      // Op controls are frozen on entry to ISSUE so they are stable for the whole op.
      if (state_d == StIssue) begin
        sel_q <= bus.select_in;
        cin_q <= bus.carry_in;
      end
      if (state_q == StCapture) begin
        result_q <= bus.alu_p;
        disp_q   <= over_max ? DISP_W'(DISP_MAX) : bus.alu_p[DISP_W-1:0];
        sat_q    <= over_max;
      end
    end
  end

  assign bus.mem_en       = (state_q == StIssue) || (state_q == StWaitMem);
  assign bus.mem_addr     = addr_q;
  assign bus.alu_select   = sel_q;
  assign bus.alu_carryin  = cin_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.disp_value   = disp_q;
  assign bus.disp_sat     = sat_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_alu_bram_sequencer.sv
// Directed bench for alu_bram_sequencer with a pipelined BRAM/ALU stub (P = addr*100).
module tb_alu_bram_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_bram_sequencer_if #(.ADDR_W(4)) ifc ();

  alu_bram_sequencer #(
    .ADDR_W   (4),
    .LAST_ADDR(3),
    .MEM_LAT  (1),
    .ALU_LAT  (3),
    .TICK_DIV (8),
    .DISP_MAX (9999)
  ) dut (
    .clock_100Mhz(clk),
    .reset_n     (rst_n),
    .bus         (ifc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Stub: one BRAM register plus four ALU stages, so P for an op appears exactly in CAPTURE.
  int          stub_mode = 0;
  logic [47:0] bram_q = '0, p1 = '0, p2 = '0, p3 = '0, p4 = '0;

  function automatic logic [47:0] stub_p(input logic [3:0] a);
    if (stub_mode == 1 && a == 4'd2) return 48'd12345;
    if (stub_mode == 1 && a == 4'd3) return 48'd42;
    return 48'(a) * 48'd100;
  endfunction

  always @(posedge clk) begin
    if (ifc.mem_en) bram_q <= stub_p(ifc.mem_addr);
    p1 <= bram_q;
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
  end
  assign ifc.alu_p = p4;

  // Event log, updated once per cycle at the falling edge.
  int          cyc_n = 0;
  int          issue_cyc = 0;
  logic        en_prev = 1'b0;
  int          done_cnt = 0;
  int          issue_q[$];
  logic [47:0] rv_res[$];
  logic [15:0] rv_disp[$];
  logic        rv_sat[$];
  int          rv_lat[$];

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (ifc.mem_en && !en_prev) begin
      issue_q.push_back(int'(ifc.mem_addr));
      issue_cyc = cyc_n;
    end
    en_prev = ifc.mem_en;
    if (ifc.result_valid) begin
      rv_res.push_back(ifc.result);
      rv_disp.push_back(ifc.disp_value);
      rv_sat.push_back(ifc.disp_sat);
      rv_lat.push_back(cyc_n - issue_cyc);
    end
    if (ifc.done) done_cnt++;
  endtask

  task automatic clear_log();
    issue_q.delete();
    rv_res.delete();
    rv_disp.delete();
    rv_sat.delete();
    rv_lat.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    {ifc.start, ifc.stop, ifc.continuous, ifc.step_mode, ifc.step, ifc.carry_in} = '0;
    ifc.select_in = 2'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({ifc.mem_en, ifc.mem_addr, ifc.alu_select, ifc.alu_carryin} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %0h, expected 0",
               {ifc.mem_en, ifc.mem_addr, ifc.alu_select, ifc.alu_carryin});
    end
    vectors++;
    if ({ifc.result, ifc.disp_value, ifc.disp_sat} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %0h, expected 0",
               {ifc.result, ifc.disp_value, ifc.disp_sat});
    end
    vectors++;
    if ({ifc.result_valid, ifc.done, ifc.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 000", {ifc.result_valid, ifc.done, ifc.busy});
    end
  endtask

  task automatic test_single_sweep();
    clear_log();
    stub_mode = 0;
    ifc.continuous = 1'b0;
    ifc.step_mode = 1'b0;
    pulse_start();
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    vectors++;
    if (ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_busy_at_done: got %b, expected 0", ifc.busy);
    end
    vectors++;
    if (rv_res.size() != 4) begin
      miscompares++;
      $display("FAIL t1_result_count: got %0d, expected 4", rv_res.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < rv_res.size()) begin
        vectors++;
        if (issue_q[k] != k) begin
          miscompares++;
          $display("FAIL t1_addr[%0d]: got %0d, expected %0d", k, issue_q[k], k);
        end
        vectors++;
        if (rv_res[k] !== 48'(k * 100) || rv_disp[k] !== 16'(k * 100) || rv_sat[k] !== 1'b0)
        begin
          miscompares++;
          $display("FAIL t1_result[%0d]: got %0d/%0d/%b, expected %0d/%0d/0", k, rv_res[k],
                   rv_disp[k], rv_sat[k], k * 100, k * 100);
        end
        vectors++;
        if (rv_lat[k] != 6) begin
          miscompares++;
          $display("FAIL t1_valid_latency[%0d]: got %0d, expected 6", k, rv_lat[k]);
        end
      end
    end
    for (int i = 0; i < 30; i++) tick();
    vectors++;
    if (done_cnt != 1 || issue_q.size() != 4) begin
      miscompares++;
      $display("FAIL t1_done_once: got done=%0d issues=%0d, expected 1/4", done_cnt,
               issue_q.size());
    end
  endtask

  task automatic test_saturation();
    clear_log();
    stub_mode = 1;
    pulse_start();
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    vectors++;
    if (rv_res.size() != 4) begin
      miscompares++;
      $display("FAIL t2_result_count: got %0d, expected 4", rv_res.size());
    end else begin
      vectors++;
      if (rv_res[2] !== 48'd12345 || rv_disp[2] !== 16'd9999 || rv_sat[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL t2_saturate: got %0d/%0d/%b, expected 12345/9999/1", rv_res[2],
                 rv_disp[2], rv_sat[2]);
      end
      vectors++;
      if (rv_res[3] !== 48'd42 || rv_disp[3] !== 16'd42 || rv_sat[3] !== 1'b0) begin
        miscompares++;
        $display("FAIL t2_unsaturate: got %0d/%0d/%b, expected 42/42/0", rv_res[3],
                 rv_disp[3], rv_sat[3]);
      end
    end
    stub_mode = 0;
  endtask

  task automatic test_continuous();
    clear_log();
    ifc.continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 300 && issue_q.size() < 10; i++) tick();
    vectors++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL t3_no_done: got %0d, expected 0", done_cnt);
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    for (int i = 0; i < 50 && done_cnt == 0; i++) tick();
    vectors++;
    if (issue_q.size() != 10 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL t3_counts: got issues=%0d done=%0d, expected 10/1", issue_q.size(),
               done_cnt);
    end
    for (int k = 0; k < 10 && k < issue_q.size(); k++) begin
      vectors++;
      if (issue_q[k] != k % 4) begin
        miscompares++;
        $display("FAIL t3_addr[%0d]: got %0d, expected %0d", k, issue_q[k], k % 4);
      end
    end
    ifc.continuous = 1'b0;
  endtask

  task automatic test_step_mode();
    clear_log();
    ifc.step_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 30 && rv_res.size() == 0; i++) tick();
    for (int i = 0; i < 50; i++) tick();
    vectors++;
    if (issue_q.size() != 1 || ifc.mem_addr !== 4'd0 || ifc.busy !== 1'b1 ||
        ifc.mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_hold: got issues=%0d addr=%0d busy=%b en=%b, expected 1/0/1/0",
               issue_q.size(), ifc.mem_addr, ifc.busy, ifc.mem_en);
    end
    ifc.step = 1'b1;
    tick();
    ifc.step = 1'b0;
    vectors++;
    if (ifc.mem_en !== 1'b1 || ifc.mem_addr !== 4'd1 || issue_q.size() != 2) begin
      miscompares++;
      $display("FAIL t4_step_issue: got en=%b addr=%0d issues=%0d, expected 1/1/2",
               ifc.mem_en, ifc.mem_addr, issue_q.size());
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    for (int i = 0; i < 30 && done_cnt == 0; i++) tick();
    vectors++;
    if (done_cnt != 1 || issue_q.size() != 2 || rv_res.size() != 2) begin
      miscompares++;
      $display("FAIL t4_stop: got done=%0d issues=%0d results=%0d, expected 1/2/2",
               done_cnt, issue_q.size(), rv_res.size());
    end
  endtask

  task automatic test_select_and_stop();
    clear_log();
    ifc.select_in = 2'd1;
    ifc.carry_in = 1'b1;
    pulse_start();
    tick();
    vectors++;
    if (ifc.alu_select !== 2'd1 || ifc.alu_carryin !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_latch_first: got %0d/%b, expected 1/1", ifc.alu_select,
               ifc.alu_carryin);
    end
    tick();
    ifc.select_in = 2'd2;
    ifc.carry_in = 1'b0;
    for (int i = 0; i < 20 && rv_res.size() == 0; i++) begin
      tick();
      vectors++;
      if (ifc.alu_select !== 2'd1 || ifc.alu_carryin !== 1'b1) begin
        miscompares++;
        $display("FAIL t5_frozen: got %0d/%b, expected 1/1", ifc.alu_select, ifc.alu_carryin);
      end
    end
    ifc.step = 1'b1;
    tick();
    ifc.step = 1'b0;
    tick();
    vectors++;
    if (ifc.alu_select !== 2'd2 || ifc.alu_carryin !== 1'b0 || ifc.mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_latch_next: got %0d/%b en=%b, expected 2/0 en=1", ifc.alu_select,
               ifc.alu_carryin, ifc.mem_en);
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    for (int i = 0; i < 20 && rv_res.size() < 2; i++) tick();
    vectors++;
    if (rv_res.size() != 2 || ifc.result !== 48'd100) begin
      miscompares++;
      $display("FAIL t5_stop_capture: got results=%0d P=%0d, expected 2/100", rv_res.size(),
               ifc.result);
    end
    for (int i = 0; i < 5 && done_cnt == 0; i++) tick();
    vectors++;
    if (done_cnt != 1 || ifc.busy !== 1'b0 || issue_q.size() != 2) begin
      miscompares++;
      $display("FAIL t5_stop_done: got done=%0d busy=%b issues=%0d, expected 1/0/2",
               done_cnt, ifc.busy, issue_q.size());
    end
  endtask

  task automatic test_reset_midop();
    clear_log();
    ifc.select_in = 2'd3;
    ifc.carry_in = 1'b1;
    pulse_start();
    tick();
    tick();
    vectors++;
    if (ifc.alu_select !== 2'd3 || ifc.busy !== 1'b1 || ifc.result !== 48'd100) begin
      miscompares++;
      $display("FAIL t6_pre_reset: got sel=%0d busy=%b P=%0d, expected 3/1/100",
               ifc.alu_select, ifc.busy, ifc.result);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.mem_en, ifc.mem_addr, ifc.alu_select, ifc.alu_carryin, ifc.busy, ifc.done,
         ifc.result_valid, ifc.disp_sat} !== 12'd0 || ifc.result !== 48'd0 ||
        ifc.disp_value !== 16'd0) begin
      miscompares++;
      $display("FAIL t6_async_reset: got sel=%0d P=%0d disp=%0d busy=%b, expected all 0",
               ifc.alu_select, ifc.result, ifc.disp_value, ifc.busy);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (rv_res.size() != 0 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_no_stale: got results=%0d busy=%b, expected 0/0", rv_res.size(),
               ifc.busy);
    end
    clear_log();
    ifc.step_mode = 1'b0;
    pulse_start();
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    vectors++;
    if (issue_q.size() != 4 || rv_res.size() != 4) begin
      miscompares++;
      $display("FAIL t6_resweep: got issues=%0d results=%0d, expected 4/4", issue_q.size(),
               rv_res.size());
    end else begin
      vectors++;
      if (issue_q[0] != 0 || rv_res[0] !== 48'd0 || rv_res[1] !== 48'd100) begin
        miscompares++;
        $display("FAIL t6_first_op: got addr=%0d P0=%0d P1=%0d, expected 0/0/100",
                 issue_q[0], rv_res[0], rv_res[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_saturation();
    test_continuous();
    test_step_mode();
    test_select_and_stop();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
